// File: rtl/rf_dump_reader.sv
// rf_dump_reader: walks a contiguous range of register-file indices through a
// spare combinational read port and streams {index, contents} words out over a
// valid/ready handshake. One LOAD cycle per word drives the read address and
// captures the data, so peak throughput is one word every two cycles.
module rf_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  ra,
    input  logic [31:0] rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);

    // Range sanity: the walk must be non-empty and stay inside a 32-entry file.
    generate
        if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
            $error("rf_dump_reader: need 0 <= FIRST_REG <= LAST_REG <= 31");
        end
    endgenerate

    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [4:0]  r_out_addr;
    logic [31:0] r_out_data;
    logic        r_out_valid;
    logic        r_done;

    logic        w_last;
    logic        w_accept;

    // The counter parks on LAST after a dump, so the address mux keeps the
    // read port pointed at FIRST whenever the block is idle.
    assign ra        = (r_state == S_IDLE) ? FIRST : r_cnt;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign done      = r_done;

    assign w_last    = (r_cnt == LAST);
    assign w_accept  = r_out_valid && out_ready;

    // Dump sequencer: IDLE -> (LOAD -> SEND)* -> IDLE, all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= FIRST;
            r_out_addr  <= 5'd0;
            r_out_data  <= 32'd0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the final accept raises it.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt   <= FIRST;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Read data is sampled here, so register-file writes are
                    // seen only by words not yet loaded.
                    r_out_data  <= rd;
                    r_out_addr  <= r_cnt;
                    r_out_valid <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 5'd1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: a per-cycle vector table for the first
// words, then hand sequences for full dump, backpressure, mid-dump writes,
// start handling, async abort and a single-register range.
module tb_rf_dump_reader;

    logic        clk;
    logic        reset;
    logic        start, out_ready;
    logic [4:0]  ra, out_addr;
    logic [31:0] rd, out_data;
    logic        out_valid, busy, done;

    logic        start5, ready5;
    logic [4:0]  ra5, addr5;
    logic [31:0] rd5, data5;
    logic        valid5, busy5, done5;

    logic [31:0] regs [32];

    int n_chk  = 0;
    int n_fail = 0;

    assign rd  = regs[ra];
    assign rd5 = regs[ra5];

    rf_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut (
        .clk(clk), .reset(reset), .start(start), .ra(ra), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .busy(busy), .done(done)
    );

    rf_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .ra(ra5), .rd(rd5),
        .out_valid(valid5), .out_ready(ready5), .out_addr(addr5),
        .out_data(data5), .busy(busy5), .done(done5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int i, input bit wr10);
        if (wr10 && i == 10) return 32'hDEAD;
        return 32'(i * 16);
    endfunction

    // Runs one dump from IDLE (called at a falling edge). Returns at the falling
    // edge where done is visible, or after an abort reset has been released.
    task automatic dump(input int stall_at, input bit wr10, input bit poke7,
                        input int abort_at, output bit got_done,
                        output int n_words, output int edges);
        int idx, stall, cyc;
        bit fin;
        idx = 0; stall = 0; cyc = 0; fin = 0; got_done = 0;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        while (!fin && cyc < 400) begin
            cyc++;
            start = 1'b0;
            if (done) begin
                got_done = 1'b1;
                fin = 1'b1;
            end else if (!out_valid) begin
                chk("load_busy", busy, 1'b1);
            end else if (idx == abort_at) begin
                #2 reset = 1'b1;
                #1;
                chk("abort_valid", out_valid, 1'b0);
                chk("abort_busy", busy, 1'b0);
                @(negedge clk);
                reset = 1'b0;
                chk("abort_no_done", done, 1'b0);
                fin = 1'b1;
            end else begin
                if (wr10 && idx == 4) regs[10] = 32'hDEAD;
                if (poke7 && idx == 7) start = 1'b1;
                if (idx == stall_at && stall < 5) begin
                    out_ready = 1'b0;
                    stall++;
                    chk("stall_addr", 32'(out_addr), 32'(stall_at));
                    chk("stall_data", out_data, exp_word(stall_at, wr10));
                end else begin
                    out_ready = 1'b1;
                    chk("word_addr", 32'(out_addr), 32'(idx));
                    chk("word_data", out_data, exp_word(idx, wr10));
                    idx++;
                end
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) begin
            n_chk++; n_fail++;
            $display("FAIL dump_timeout: no done after %0d cycles, expected done", cyc);
        end
        n_words = idx;
        edges   = cyc - 1;
    endtask

    typedef struct {
        logic        start;
        logic        ready;
        logic        exp_valid;
        logic        exp_busy;
        logic        exp_done;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic        chk_word;
        logic [4:0]  exp_ra;
        logic        chk_ra;
    } vec_t;

    vec_t tbl [11];

    initial begin
        bit gd;
        int nw, ne;

        // Per-cycle vectors from IDLE: start, stalls, ignored start/ready.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h00, 1'b1, 5'd0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h00, 1'b0, 5'd0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h00, 1'b1, 5'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h00, 1'b1, 5'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h00, 1'b0, 5'd1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 32'h10, 1'b1, 5'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h00, 1'b0, 5'd2, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'h20, 1'b1, 5'd0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h20, 1'b1, 5'd0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h00, 1'b0, 5'd3, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h30, 1'b1, 5'd0, 1'b0};

        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 16);
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; start5 = 1'b0; ready5 = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", 32'(out_addr), 0);
        chk("rst_data", out_data, 0);
        chk("rst_ra", 32'(ra), 0);
        chk("rst_ra5", 32'(ra5), 5);
        chk("rst_valid5", valid5, 1'b0);
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < 11; i++) begin
            start = tbl[i].start; out_ready = tbl[i].ready;
            chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].exp_valid);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].exp_busy);
            chk($sformatf("vec%0d_done", i), done, tbl[i].exp_done);
            if (tbl[i].chk_word) begin
                chk($sformatf("vec%0d_addr", i), 32'(out_addr), 32'(tbl[i].exp_addr));
                chk($sformatf("vec%0d_data", i), out_data, tbl[i].exp_data);
            end
            if (tbl[i].chk_ra) chk($sformatf("vec%0d_ra", i), 32'(ra), 32'(tbl[i].exp_ra));
            @(posedge clk); @(negedge clk);
        end
        start = 1'b0;
        reset = 1'b1; @(negedge clk); reset = 1'b0;

        // Full dump, ready held high
        dump(-1, 1'b0, 1'b0, -1, gd, nw, ne);
        chk("full_done", gd, 1'b1);
        chk("full_words", nw, 32);
        chk("full_edges", ne, 64);
        @(negedge clk);
        chk("full_done_pulse", done, 1'b0);
        chk("full_busy_after", busy, 1'b0);

        // Backpressure on word 3, r10 written while word 4 pending, start poked at word 7
        dump(3, 1'b1, 1'b1, -1, gd, nw, ne);
        regs[10] = 32'hA0;
        chk("bp_done", gd, 1'b1);
        chk("bp_words", nw, 32);
        chk("bp_edges", ne, 69);
        // start in the done cycle begins a second dump
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk("chain_load_valid", out_valid, 1'b0);
        chk("chain_load_busy", busy, 1'b1);
        chk("chain_done_low", done, 1'b0);
        @(negedge clk);
        chk("chain_valid", out_valid, 1'b1);
        chk("chain_addr", 32'(out_addr), 0);
        chk("chain_data", out_data, 0);
        reset = 1'b1; @(negedge clk); reset = 1'b0;

        // Async abort while word 12 is presented, then a clean restart
        dump(-1, 1'b0, 1'b0, 12, gd, nw, ne);
        chk("abort_got_done", gd, 1'b0);
        chk("abort_words", nw, 12);
        dump(-1, 1'b0, 1'b0, -1, gd, nw, ne);
        chk("restart_done", gd, 1'b1);
        chk("restart_words", nw, 32);

        // Single-register range 5..5
        regs[5] = 32'h55;
        start5 = 1'b1; ready5 = 1'b1;
        @(posedge clk); @(negedge clk);
        start5 = 1'b0;
        chk("one_load_ra", 32'(ra5), 5);
        chk("one_load_valid", valid5, 1'b0);
        chk("one_load_busy", busy5, 1'b1);
        @(negedge clk);
        chk("one_valid", valid5, 1'b1);
        chk("one_addr", 32'(addr5), 5);
        chk("one_data", data5, 32'h55);
        @(negedge clk);
        chk("one_valid_drop", valid5, 1'b0);
        chk("one_done", done5, 1'b1);
        @(negedge clk);
        chk("one_done_pulse", done5, 1'b0);
        chk("one_busy_after", busy5, 1'b0);
        regs[5] = 32'h50;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
